// File: rtl/phasor_pkg.sv
// Shared definitions for the phasor synthesis/analysis blocks.
package phasor_pkg;

  localparam int PHASE_W = 8;
  localparam int MAG_W   = 4;
  localparam int FREQ_W  = 4;

  typedef enum logic [1:0] {IDLE, ACCUM, SCALE, DONE} demod_state_e;

endpackage

// File: rtl/phasor_ref_rom.sv
// Combinational sine/cosine reference: 65-entry quarter-wave table with
// quadrant folding. Peak magnitude 511.
module phasor_ref_rom
  import phasor_pkg::*;
#(
  parameter int COEF_W = 10
) (
  input  logic        [PHASE_W-1:0] phase,
  output logic signed [COEF_W-1:0]  sin_ref,
  output logic signed [COEF_W-1:0]  cos_ref
);

  localparam int QTAB [65] = '{
      0,  13,  25,  38,  50,  63,  75,  87, 100, 112,
    124, 136, 148, 160, 172, 184, 196, 207, 218, 230,
    241, 252, 263, 273, 284, 294, 304, 314, 324, 334,
    343, 352, 361, 370, 379, 387, 395, 403, 410, 418,
    425, 432, 438, 445, 451, 456, 462, 467, 472, 477,
    481, 485, 489, 492, 496, 499, 501, 503, 505, 507,
    509, 510, 510, 511, 511
  };

  // Quadrants 1 and 3 read the table mirrored; the upper half is negated.
  function automatic logic signed [COEF_W-1:0] fold(input logic [PHASE_W-1:0] p);
    logic [6:0]               idx;
    logic signed [COEF_W-1:0] v;
    idx = p[6] ? (7'd64 - {1'b0, p[5:0]}) : {1'b0, p[5:0]};
    v   = COEF_W'(QTAB[idx]);
    return p[7] ? -v : v;
  endfunction

  assign sin_ref = fold(phase);
  assign cos_ref = fold(phase + PHASE_W'(64));

endmodule

// File: rtl/phasor_demod.sv
// Single-bin quadrature demodulator over a 2^WINDOW_LOG2 sample window.
// Build option: PHASOR_DEMOD_ROUND_EN selects round-half-up magnitudes.
module phasor_demod
  import phasor_pkg::*;
#(
  parameter int SAMPLE_W    = 20,
  parameter int COEF_W      = 10,
  parameter int WINDOW_LOG2 = 6,
  parameter int MAG_SHIFT   = 29
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic        [FREQ_W-1:0]   freq,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  input  logic                       sample_valid,
  output logic                       sample_ready,
  output logic                       busy,
  output logic                       done,
  output logic        [MAG_W-1:0]    sin_mag,
  output logic        [MAG_W-1:0]    cos_mag,
  output logic                       sin_neg,
  output logic                       cos_neg
);

  localparam int ACC_W  = SAMPLE_W + COEF_W + WINDOW_LOG2;
  localparam int PROD_W = SAMPLE_W + COEF_W;

  demod_state_e               state, state_nxt;
  logic [PHASE_W-1:0]         phase;
  logic [FREQ_W-1:0]          freq_q;
  logic [WINDOW_LOG2-1:0]     count;
  logic signed [ACC_W-1:0]    sin_acc, cos_acc;
  logic signed [COEF_W-1:0]   sin_ref, cos_ref;
  logic signed [PROD_W-1:0]   sin_prod, cos_prod;
  logic                       accept, hs, last;

  phasor_ref_rom #(.COEF_W(COEF_W)) u_rom (
    .phase   (phase),
    .sin_ref (sin_ref),
    .cos_ref (cos_ref)
  );

  assign accept       = (state == IDLE) && start;
  assign sample_ready = (state == ACCUM);
  assign busy         = (state != IDLE);
  assign done         = (state == DONE);
  assign hs           = sample_valid && sample_ready;
  assign last         = (count == {WINDOW_LOG2{1'b1}});
  assign sin_prod     = sample_in * sin_ref;
  assign cos_prod     = sample_in * cos_ref;

  // |acc| is formed one bit wider so the most negative value does not wrap.
  function automatic logic [MAG_W-1:0] sat_mag(input logic signed [ACC_W-1:0] acc);
    logic [ACC_W:0] a, s;
    a = acc[ACC_W-1] ? (~{acc[ACC_W-1], acc} + (ACC_W+1)'(1)) : {1'b0, acc};
`ifdef PHASOR_DEMOD_ROUND_EN
    a = a + ((ACC_W+1)'(1) << (MAG_SHIFT-1));
`else
    a = a;
`endif
    s = a >> MAG_SHIFT;
    return (s > (ACC_W+1)'({MAG_W{1'b1}})) ? {MAG_W{1'b1}} : s[MAG_W-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)     state_nxt = ACCUM;
      ACCUM:   if (hs && last) state_nxt = SCALE;
      SCALE:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sin_acc <= '0;
      cos_acc <= '0;
      phase   <= '0;
      count   <= '0;
      freq_q  <= '0;
      sin_mag <= '0;
      cos_mag <= '0;
      sin_neg <= 1'b0;
      cos_neg <= 1'b0;
    end else begin
      if (accept) begin
        sin_acc <= '0;
        cos_acc <= '0;
        phase   <= '0;
        count   <= '0;
        freq_q  <= freq;
      end
      if (hs) begin
        sin_acc <= sin_acc + ACC_W'(sin_prod);
        cos_acc <= cos_acc + ACC_W'(cos_prod);
        phase   <= phase + PHASE_W'({freq_q, 2'b00});
        count   <= count + 1'b1;
      end
      if (state == SCALE) begin
        sin_mag <= sat_mag(sin_acc);
        cos_mag <= sat_mag(cos_acc);
        sin_neg <= sin_acc[ACC_W-1];
        cos_neg <= cos_acc[ACC_W-1];
      end
    end
  end

endmodule

// File: tb/tb_phasor_demod.sv
// Scoreboard bench for phasor_demod: a real-valued reference model predicts
// each window's result when its stimulus is issued.
module tb_phasor_demod;

  logic               clk = 1'b0;
  logic               reset, start, sample_valid;
  logic [3:0]         freq;
  logic signed [19:0] sample_in;
  logic               sample_ready, busy, done, sin_neg, cos_neg;
  logic [3:0]         sin_mag, cos_mag;

  int checks = 0;
  int passes = 0;

  typedef struct {int sm; bit sn; int cm; bit cn;} exp_t;
  exp_t q[$];

  phasor_demod dut (
    .clk(clk), .reset(reset), .start(start), .freq(freq),
    .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .busy(busy), .done(done),
    .sin_mag(sin_mag), .cos_mag(cos_mag), .sin_neg(sin_neg), .cos_neg(cos_neg)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic int rnd(input real v);
    return (v >= 0.0) ? $rtoi($floor(v + 0.5)) : -$rtoi($floor(-v + 0.5));
  endfunction

  function automatic int ref_sin(input int ph);
    return rnd(511.0 * $sin(2.0 * 3.14159265358979 * ph / 256.0));
  endfunction

  function automatic int gen(input int kind, input int n);
    real w;
    w = 2.0 * 3.14159265358979 * n / 64.0;
    case (kind)
      0:       return rnd(262144.0 * $sin(w));
      1:       return rnd(-524287.0 * $cos(3.0 * w));
      default: return 524287;
    endcase
  endfunction

  function automatic int mag(input longint a);
    longint m;
    m = (a < 0) ? -a : a;
`ifdef PHASOR_DEMOD_ROUND_EN
    m = m + (longint'(1) << 28);
`endif
    m = m >>> 29;
    return (m > 15) ? 15 : int'(m);
  endfunction

  // gap: idle cycles before each sample; abuse: protocol misuse; rst_at: reset before sample n
  task automatic run_window(input int f, input int kind, input int gap, input bit abuse,
                            input int rst_at, input string tag);
    exp_t   e;
    longint sa = 0, ca = 0;
    int     ph = 0, lat;
    for (int n = 0; n < 64; n++) begin
      sa += longint'(gen(kind, n)) * ref_sin(ph);
      ca += longint'(gen(kind, n)) * ref_sin((ph + 64) % 256);
      ph = (ph + 4 * f) % 256;
    end
    e.sm = mag(sa); e.sn = (sa < 0); e.cm = mag(ca); e.cn = (ca < 0);
    q.push_back(e);

    if (abuse) begin
      sample_valid = 1'b1; sample_in = 20'sh12345;
      repeat (3) step();
      checks++;
      if (sample_ready !== 1'b0 || busy !== 1'b0)
        $display("FAIL %s idle_ready: ready=%b busy=%b want 0 0", tag, sample_ready, busy);
      else passes++;
    end
    freq = 4'(f); start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (sample_ready !== 1'b1 || busy !== 1'b1)
      $display("FAIL %s ready_after_start: ready=%b busy=%b want 1 1", tag, sample_ready, busy);
    else passes++;

    for (int n = 0; n < 64; n++) begin
      repeat (gap) begin sample_valid = 1'b0; step(); end
      if (n == rst_at) begin
        sample_valid = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if ({sample_ready, busy, done, sin_neg, cos_neg, sin_mag, cos_mag} !== 13'd0)
          $display("FAIL %s mid_reset: outs=%h want 0", tag,
                   {sample_ready, busy, done, sin_neg, cos_neg, sin_mag, cos_mag});
        else passes++;
        void'(q.pop_back());
        return;
      end
      if (abuse) begin
        if (n == 10) freq = 4'd5;
        start = (n == 20);
      end
      checks++;
      if (sample_ready !== 1'b1)
        $display("FAIL %s ready_in_window: n=%0d ready=%b want 1", tag, n, sample_ready);
      else passes++;
      sample_valid = 1'b1; sample_in = 20'(gen(kind, n));
      step();
    end
    sample_valid = 1'b0; start = 1'b0;

    lat = 1;
    while (done !== 1'b1 && lat < 8) begin step(); lat++; end
    e = q.pop_front();
    checks++;
    if (done !== 1'b1) begin
      $display("FAIL %s done_timeout: done=%b after %0d cycles want 1", tag, done, lat);
    end else begin
      passes++;
      checks++;
      if (lat !== 2) $display("FAIL %s done_latency: got %0d want 2", tag, lat);
      else passes++;
      checks++;
      if (sin_mag !== 4'(e.sm) || sin_neg !== e.sn || cos_mag !== 4'(e.cm) || cos_neg !== e.cn)
        $display("FAIL %s result: sin=%0d/%b cos=%0d/%b want sin=%0d/%b cos=%0d/%b", tag,
                 sin_mag, sin_neg, cos_mag, cos_neg, e.sm, e.sn, e.cm, e.cn);
      else passes++;
    end
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0)
      $display("FAIL %s done_pulse: done=%b busy=%b want 0 0", tag, done, busy);
    else passes++;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; sample_valid = 1'b0; freq = 4'd0; sample_in = '0;
    repeat (2) step();
    checks++;
    if ({sample_ready, busy, done, sin_neg, cos_neg, sin_mag, cos_mag} !== 13'd0)
      $display("FAIL reset_values: outs=%h want 0",
               {sample_ready, busy, done, sin_neg, cos_neg, sin_mag, cos_mag});
    else passes++;
    start = 1'b1; freq = 4'd1;
    step();
    start = 1'b0;
    checks++;
    if (busy !== 1'b0) $display("FAIL reset_beats_start: busy=%b want 0", busy);
    else passes++;
    reset = 1'b0;
    step();
  endtask

  task automatic test_freq1();
    run_window(1, 0, 0, 1'b0, -1, "freq1");
    checks++;
`ifdef PHASOR_DEMOD_ROUND_EN
    if (sin_mag !== 4'd8 || sin_neg !== 1'b0 || cos_mag !== 4'd0)
      $display("FAIL freq1_const: sin=%0d/%b cos=%0d want 8/0 0", sin_mag, sin_neg, cos_mag);
`else
    if (sin_mag !== 4'd7 || sin_neg !== 1'b0 || cos_mag !== 4'd0)
      $display("FAIL freq1_const: sin=%0d/%b cos=%0d want 7/0 0", sin_mag, sin_neg, cos_mag);
`endif
    else passes++;
  endtask

  task automatic test_mid_reset();
    run_window(1, 0, 0, 1'b0, 30, "midreset");
    run_window(1, 0, 0, 1'b0, -1, "after_reset");
  endtask

  task automatic test_freq3();
    run_window(3, 1, 0, 1'b0, -1, "freq3");
    checks++;
    if (cos_mag !== 4'd15 || cos_neg !== 1'b1 || sin_mag !== 4'd0)
      $display("FAIL freq3_const: cos=%0d/%b sin=%0d want 15/1 0", cos_mag, cos_neg, sin_mag);
    else passes++;
  endtask

  task automatic test_backpressure();
    run_window(1, 0, 2, 1'b0, -1, "backpressure");
  endtask

  task automatic test_abuse();
    run_window(1, 0, 0, 1'b1, -1, "abuse");
  endtask

  task automatic test_freq0();
    run_window(0, 2, 0, 1'b0, -1, "freq0");
    checks++;
    if (cos_mag !== 4'd15 || cos_neg !== 1'b0 || sin_mag !== 4'd0)
      $display("FAIL freq0_const: cos=%0d/%b sin=%0d want 15/0 0", cos_mag, cos_neg, sin_mag);
    else passes++;
  endtask

  task automatic test_back_to_back();
    run_window(3, 1, 0, 1'b0, -1, "b2b_a");
    run_window(1, 0, 0, 1'b0, -1, "b2b_b");
  endtask

  initial begin
    test_reset();
    test_freq1();
    test_mid_reset();
    test_freq3();
    test_backpressure();
    test_abuse();
    test_freq0();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/phasor_demod.md
# phasor_demod

Single-bin quadrature demodulator: the analysis counterpart of `phasor`. It correlates a stream of signed 20-bit samples against internal sine and cosine references at a programmable integer frequency over a fixed window. It reports quantized sine and cosine magnitudes and signs in the same 4-bit format that `phasor` consumes. It sits between a sample source (the `phasor` outputs or an ADC path) and HPS-readable PIOs.

## Interface
- `SAMPLE_W`, 20: signed input sample width.
- `COEF_W`, 10: signed reference coefficient width; peak is 2^(COEF_W-1)-1 = 511.
- `WINDOW_LOG2`, 6: window length N = 2^WINDOW_LOG2 = 64 samples.
- `MAG_SHIFT`, 29: right shift applied to |accumulator| before saturation to 4 bits.
- `clk`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a measurement window.
- `freq`  in  4  reference frequency in cycles per window; latched on accepted `start`.
- `sample_in`  in  SAMPLE_W  signed sample.
- `sample_valid`  in  1  `sample_in` is valid this cycle.
- `sample_ready`  out  1  block accepts a sample this cycle.
- `busy`  out  1  high from accepted `start` until `done`.
- `done`  out  1  one-cycle pulse when results update.
- `sin_mag`, `cos_mag`  out  4  unsigned saturated magnitudes.
- `sin_neg`, `cos_neg`  out  1  sign of the corresponding accumulator (1 = negative).

## Operation
- Accumulator width ACC_W = SAMPLE_W + COEF_W + WINDOW_LOG2 = 36, signed.
- 8-bit phase accumulator. Step = {freq, 2'b00}, mod 256.
- Reference values: sin_ref = round(511·sin(2π·phase/256)), cos_ref = sin_ref at phase+64.
- FSM states and transitions:
  - IDLE: `sample_ready`=0. An accepted `start` clears both accumulators, phase and count, latches `freq`, and moves to ACCUM.
  - ACCUM: `sample_ready`=1. On each handshake (valid & ready):
    - sin_acc += sample·sin_ref and cos_acc += sample·cos_ref, using full-precision signed products.
    - phase += step and count += 1.
    - After the N-th handshake, move to SCALE.
  - SCALE: compute each output as mag = min(15, |acc| >> MAG_SHIFT) and neg = acc[ACC_W-1]; register all outputs; move to DONE.
  - DONE: `done`=1 for one cycle; return to IDLE.
- `busy` = (state != IDLE).
- `start` is ignored outside IDLE.
- `sample_valid` is ignored while `sample_ready`=0.
- Changes to `freq` after the accepted `start` have no effect on the current window.
- freq=0: sin_ref ≡ 0 and cos_ref ≡ 511. `cos_mag` measures DC and `sin_mag` is 0.
- |acc| of the most negative value must not overflow: compute it in ACC_W+1 bits.
- Results hold until the next SCALE or until reset.

## Timing
- Reset value of every output: `sample_ready`, `busy`, `done`, `sin_mag`, `cos_mag`, `sin_neg`, `cos_neg` are all 0.
- Reset takes effect on the next edge in any state, including mid-window. Partial accumulation is discarded and the FSM returns to IDLE.
- `reset` and `start` in the same cycle: `reset` wins.
- `sample_ready` rises the cycle after an accepted `start`.
- Latency from the N-th handshake:
  - SCALE is active on the next cycle.
  - Outputs update and `done`=1 two cycles after the handshake edge.
- Back-to-back operation: the earliest next `start` is accepted in the cycle after `done`.
- Arbitrary gaps in `sample_valid` only stretch ACCUM. Results do not depend on the gap pattern.

## Configuration
- `PHASOR_DEMOD_ROUND_EN` defined: the magnitude is (|acc| + 2^(MAG_SHIFT-1)) >> MAG_SHIFT, then saturated to 15 (round half-up).
- Not defined: plain truncation.
- Signs, timing and ports are identical in both builds.

## Structure
- Shared package `phasor_pkg` holds:
  - constants `PHASE_W`=8, `MAG_W`=4, `FREQ_W`=4;
  - the FSM state enum (IDLE, ACCUM, SCALE, DONE).
- Sub-module `phasor_ref_rom`:
  - combinational quarter-wave sine table of 65 entries (index 64 = 511) with quadrant folding;
  - takes 8-bit phase and returns signed `COEF_W` sin and cos.
  - `phasor` may reuse it.

## Test plan
- Reset: assert `reset` mid-ACCUM after 30 samples → the next cycle shows IDLE, all outputs 0. A following window with freq=1 and the test-2 stimulus gives test-2 results.
- freq=1, x[n]=round(2^18·sin(2πn/64)), 64 back-to-back samples:
  - `sin_mag`=7, `sin_neg`=0, `cos_mag`=0;
  - with `PHASOR_DEMOD_ROUND_EN`, `sin_mag`=8;
  - `done` fires 2 cycles after the 64th handshake.
- freq=3, x[n]=-(2^19-1)·cos(2π·3n/64) → `cos_mag`=15 (saturated), `cos_neg`=1, `sin_mag`=0.
- Backpressure: test 2 with `sample_valid` high every third cycle → identical results; `done` 2 cycles after the 64th accepted sample.
- Protocol abuse:
  - `sample_valid` held high in IDLE is ignored; `start` pulsed during ACCUM is ignored;
  - `freq` changed mid-window from 1 to 5 → results still match test 2.
- freq=0 with constant x=2^19-1 → `cos_mag`=15, `cos_neg`=0, `sin_mag`=0.
